rob_alloc_commit: RTL and testbench

- 2-wide reorder buffer: the responder to rename's ROB allocation requests and the source of its commit_write_ports.
- Grants tags from a circular buffer; records rd and has_rd per entry; captures results from the CDB; retires up to PIPE_WIDTH completed entries per cycle in program order.
- Drives registered commit ports to the PRF and to rename's commit bypass.

---
 rtl/uarch_pkg.sv | 33 +++
 rtl/rob_alloc_commit.sv | 115 +++++++++++
 tb/tb_rob_alloc_commit.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uarch_pkg.sv
// Shared microarchitecture types: ROB geometry, ROB entry and PRF commit port layout.
// Pointer helpers operate on wrap-bit-extended ROB pointers.
package uarch_pkg;
    localparam int PIPE_WIDTH = 2;
    localparam int ROB_DEPTH  = 32;
    localparam int TAG_WIDTH  = $clog2(ROB_DEPTH);

    typedef logic [TAG_WIDTH:0] rob_ptr_t;

    typedef struct packed {
        logic                 we;
        logic [4:0]           addr;
        logic [TAG_WIDTH-1:0] tag;
        logic [31:0]          data;
    } prf_commit_write_port_t;

    typedef struct packed {
        logic        valid;
        logic        done;
        logic        has_rd;
        logic [4:0]  rd;
        logic [31:0] data;
    } rob_entry_t;

    // Extra MSB acts as the wrap bit, so plain addition gives modulo-2*DEPTH pointers.
    function automatic rob_ptr_t ptr_add(rob_ptr_t p, logic [1:0] n);
        return p + rob_ptr_t'(n);
    endfunction

    function automatic logic [TAG_WIDTH-1:0] ptr_idx(rob_ptr_t p);
        return p[TAG_WIDTH-1:0];
    endfunction
endpackage

// File: rtl/rob_alloc_commit.sv
// 2-wide reorder buffer: all-or-nothing tag grant, CDB capture, in-order commit of up to 2/cycle.
// Grant is combinational; commit ports are registered one cycle after the commit decision.
module rob_alloc_commit
    import uarch_pkg::*;
#(
    parameter int CDB_PORTS = 2
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     flush,
    input  logic [PIPE_WIDTH-1:0]                    rob_alloc_req,
    input  logic [PIPE_WIDTH-1:0][4:0]               alloc_rd,
    input  logic [PIPE_WIDTH-1:0]                    alloc_has_rd,
    output logic [PIPE_WIDTH-1:0]                    rob_alloc_gnt,
    output logic [PIPE_WIDTH-1:0][TAG_WIDTH-1:0]     rob_alloc_tags,
    input  logic [CDB_PORTS-1:0]                     cdb_valid,
    input  logic [CDB_PORTS-1:0][TAG_WIDTH-1:0]      cdb_tag,
    input  logic [CDB_PORTS-1:0][31:0]               cdb_data,
    output prf_commit_write_port_t [PIPE_WIDTH-1:0]  commit_write_ports,
    output logic                                     rob_empty,
    output logic [TAG_WIDTH:0]                       rob_count
);
    localparam logic [TAG_WIDTH+1:0] DEPTH_W = (TAG_WIDTH+2)'(ROB_DEPTH);

    rob_entry_t entries [ROB_DEPTH];

    rob_ptr_t             head;
    rob_ptr_t             tail;
    rob_ptr_t             count;
    logic [1:0]           n_req;
    logic [1:0]           n_gnt;
    logic [1:0]           n_inflight;
    logic [1:0]           n_commit;
    logic [TAG_WIDTH+1:0] need;
    logic [TAG_WIDTH-1:0] head_idx;
    logic [TAG_WIDTH-1:0] head1_idx;
    rob_entry_t           e0;
    rob_entry_t           e1;
    logic                 c0;
    logic                 c1;

    always_comb begin
        count      = tail - head;
        n_req      = {1'b0, rob_alloc_req[0]} + {1'b0, rob_alloc_req[1]};
        // Tags still showing on the commit ports are not reusable yet.
        n_inflight = {1'b0, commit_write_ports[0].we} + {1'b0, commit_write_ports[1].we};
        need       = (TAG_WIDTH+2)'(count) + (TAG_WIDTH+2)'(n_req) + (TAG_WIDTH+2)'(n_inflight);

        rob_alloc_tags[0] = ptr_idx(tail);
        rob_alloc_tags[1] = ptr_idx(ptr_add(tail, {1'b0, rob_alloc_req[0]}));
        rob_alloc_gnt     = (need <= DEPTH_W && !flush) ? rob_alloc_req : '0;
        n_gnt             = {1'b0, rob_alloc_gnt[0]} + {1'b0, rob_alloc_gnt[1]};

        head_idx  = ptr_idx(head);
        head1_idx = ptr_idx(ptr_add(head, 2'd1));
        e0        = entries[head_idx];
        e1        = entries[head1_idx];
        c0        = !flush && e0.valid && e0.done;
        c1        = c0 && e1.valid && e1.done;
        n_commit  = {1'b0, c0} + {1'b0, c1};

        rob_count = count;
        rob_empty = (count == '0);
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                entries[i].valid <= 1'b0;
                entries[i].done  <= 1'b0;
            end
        end else begin
            // done is only visible to the commit check from the next cycle on.
            for (int p = 0; p < CDB_PORTS; p++) begin
                if (cdb_valid[p] && entries[cdb_tag[p]].valid) begin
                    entries[cdb_tag[p]].done <= 1'b1;
                    entries[cdb_tag[p]].data <= cdb_data[p];
                end
            end
            if (c0) begin
                entries[head_idx].valid <= 1'b0;
                entries[head_idx].done  <= 1'b0;
            end
            if (c1) begin
                entries[head1_idx].valid <= 1'b0;
                entries[head1_idx].done  <= 1'b0;
            end
            // Allocation comes last so it overrides any CDB write to the same slot.
            for (int s = 0; s < PIPE_WIDTH; s++) begin
                if (rob_alloc_gnt[s]) begin
                    entries[rob_alloc_tags[s]] <= '{valid: 1'b1, done: 1'b0,
                                                   has_rd: alloc_has_rd[s],
                                                   rd: alloc_rd[s], data: 32'd0};
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head               <= '0;
            tail               <= '0;
            commit_write_ports <= '0;
        end else begin
            head <= ptr_add(head, n_commit);
            tail <= ptr_add(tail, n_gnt);
            commit_write_ports[0] <= c0 ? '{we: e0.has_rd && (e0.rd != 5'd0), addr: e0.rd,
                                            tag: head_idx, data: e0.data}
                                        : '0;
            commit_write_ports[1] <= c1 ? '{we: e1.has_rd && (e1.rd != 5'd0), addr: e1.rd,
                                            tag: head1_idx, data: e1.data}
                                        : '0;
        end
    end
endmodule

// File: tb/tb_rob_alloc_commit.sv
// Bench for rob_alloc_commit: queue-based ROB model checked every cycle, plus directed scenarios.
module tb_rob_alloc_commit;
    import uarch_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                               rst;
    logic                               flush;
    logic [1:0]                         rob_alloc_req;
    logic [1:0][4:0]                    alloc_rd;
    logic [1:0]                         alloc_has_rd;
    logic [1:0]                         rob_alloc_gnt;
    logic [1:0][TAG_WIDTH-1:0]          rob_alloc_tags;
    logic [1:0]                         cdb_valid;
    logic [1:0][TAG_WIDTH-1:0]          cdb_tag;
    logic [1:0][31:0]                   cdb_data;
    prf_commit_write_port_t [1:0]       commit_write_ports;
    logic                               rob_empty;
    logic [TAG_WIDTH:0]                 rob_count;

    int total = 0;
    int bad   = 0;

    rob_alloc_commit #(.CDB_PORTS(2)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .rob_alloc_req(rob_alloc_req), .alloc_rd(alloc_rd), .alloc_has_rd(alloc_has_rd),
        .rob_alloc_gnt(rob_alloc_gnt), .rob_alloc_tags(rob_alloc_tags),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .commit_write_ports(commit_write_ports), .rob_empty(rob_empty), .rob_count(rob_count)
    );

    // Model: program-ordered queue of live entries, next tag to hand out, expected commit ports.
    typedef struct {
        int          tag;
        logic [4:0]  rd;
        logic        has_rd;
        logic        done;
        logic [31:0] data;
    } ment_t;

    ment_t                  q[$];
    int                     mtail;
    prf_commit_write_port_t mport[2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        q.delete();
        mtail    = 0;
        mport[0] = '0;
        mport[1] = '0;
    endtask

    function automatic logic [1:0] m_gnt();
        int nreq;
        int inflight;
        nreq     = int'(rob_alloc_req[0]) + int'(rob_alloc_req[1]);
        inflight = int'(mport[0].we) + int'(mport[1].we);
        if (!flush && nreq <= ROB_DEPTH - q.size() - inflight) return rob_alloc_req;
        return 2'b00;
    endfunction

    function automatic int m_tag(input int s);
        if (s == 0) return mtail % ROB_DEPTH;
        return (mtail + int'(rob_alloc_req[0])) % ROB_DEPTH;
    endfunction

    task automatic idle();
        rob_alloc_req = '0;
        alloc_rd      = '0;
        alloc_has_rd  = '0;
        cdb_valid     = '0;
        cdb_tag       = '0;
        cdb_data      = '0;
        flush         = 1'b0;
        rst           = 1'b0;
    endtask

    // Called #1 after a negedge with inputs applied; returns at the following negedge.
    task automatic cycle();
        logic [1:0]             g;
        int                     c;
        prf_commit_write_port_t np[2];
        chk("gnt",  64'(rob_alloc_gnt),     64'(m_gnt()));
        chk("tag0", 64'(rob_alloc_tags[0]), 64'(m_tag(0)));
        chk("tag1", 64'(rob_alloc_tags[1]), 64'(m_tag(1)));
        g = m_gnt();
        if (rst || flush) begin
            m_reset();
        end else begin
            c = 0;
            if (q.size() > 0 && q[0].done) c = 1;
            if (c == 1 && q.size() > 1 && q[1].done) c = 2;
            for (int i = 0; i < 2; i++) begin
                np[i] = '0;
                if (i < c) begin
                    np[i].we   = q[i].has_rd && (q[i].rd != 5'd0);
                    np[i].addr = q[i].rd;
                    np[i].tag  = TAG_WIDTH'(q[i].tag);
                    np[i].data = q[i].data;
                end
            end
            for (int p = 0; p < 2; p++) begin
                if (cdb_valid[p]) begin
                    foreach (q[k]) begin
                        if (q[k].tag == int'(cdb_tag[p])) begin
                            q[k].done = 1'b1;
                            q[k].data = cdb_data[p];
                        end
                    end
                end
            end
            repeat (c) void'(q.pop_front());
            for (int s = 0; s < 2; s++) begin
                if (g[s]) begin
                    q.push_back('{tag: mtail, rd: alloc_rd[s], has_rd: alloc_has_rd[s],
                                  done: 1'b0, data: 32'd0});
                    mtail = (mtail + 1) % ROB_DEPTH;
                end
            end
            mport[0] = np[0];
            mport[1] = np[1];
        end
        @(posedge clk);
        @(negedge clk);
        chk("count", 64'(rob_count), 64'(q.size()));
        chk("empty", 64'(rob_empty), 64'(q.size() == 0));
        chk("port0", 64'(commit_write_ports[0]), 64'(mport[0]));
        chk("port1", 64'(commit_write_ports[1]), 64'(mport[1]));
    endtask

    task automatic rst_cycle();
        idle();
        rst = 1'b1;
        #1;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        int rate;
        idle();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_reset();
        chk("rst_count", 64'(rob_count), 64'd0);
        chk("rst_empty", 64'(rob_empty), 64'd1);
        chk("rst_ports", 64'(commit_write_ports), 64'd0);

        // Dual alloc, then in-order writeback and commit
        rob_alloc_req = 2'b11; alloc_rd[0] = 5'd3; alloc_rd[1] = 5'd5; alloc_has_rd = 2'b11;
        #1;
        chk("t1_gnt",  64'(rob_alloc_gnt), 64'd3);
        chk("t1_tag0", 64'(rob_alloc_tags[0]), 64'd0);
        chk("t1_tag1", 64'(rob_alloc_tags[1]), 64'd1);
        cycle();
        chk("t1_count", 64'(rob_count), 64'd2);
        idle(); cdb_valid = 2'b01; cdb_tag[0] = 5'd0; cdb_data[0] = 32'hAA; #1; cycle();
        idle(); cdb_valid = 2'b01; cdb_tag[0] = 5'd1; cdb_data[0] = 32'hBB; #1; cycle();
        chk("wb_c3_port0", 64'(commit_write_ports[0]), 64'({1'b1, 5'd3, 5'd0, 32'hAA}));
        chk("wb_c3_port1_we", 64'(commit_write_ports[1].we), 64'd0);
        idle(); #1; cycle();
        chk("wb_c4_port0", 64'(commit_write_ports[0]), 64'({1'b1, 5'd5, 5'd1, 32'hBB}));
        chk("wb_c4_empty", 64'(rob_empty), 64'd1);

        // Slot-1-only request on an empty ROB
        rst_cycle();
        rob_alloc_req = 2'b10; alloc_rd[1] = 5'd7; alloc_has_rd = 2'b10;
        #1;
        chk("t2_gnt",  64'(rob_alloc_gnt), 64'd2);
        chk("t2_tag1", 64'(rob_alloc_tags[1]), 64'd0);
        cycle();
        chk("t2_count", 64'(rob_count), 64'd1);
        idle(); rob_alloc_req = 2'b01; alloc_rd[0] = 5'd9; alloc_has_rd = 2'b01;
        #1;
        chk("t2_next_tag0", 64'(rob_alloc_tags[0]), 64'd1);
        cycle();

        // Out-of-order completion: younger first, both retire together
        idle(); cdb_valid = 2'b10; cdb_tag[1] = 5'd1; cdb_data[1] = 32'h11; #1; cycle();
        idle(); #1; cycle();
        chk("ooo_hold_we0", 64'(commit_write_ports[0].we), 64'd0);
        chk("ooo_hold_cnt", 64'(rob_count), 64'd2);
        idle(); cdb_valid = 2'b01; cdb_tag[0] = 5'd0; cdb_data[0] = 32'h22; #1; cycle();
        idle(); #1; cycle();
        chk("ooo_port0", 64'(commit_write_ports[0]), 64'({1'b1, 5'd7, 5'd0, 32'h22}));
        chk("ooo_port1", 64'(commit_write_ports[1]), 64'({1'b1, 5'd9, 5'd1, 32'h11}));

        // Fill to full, retire two, check the in-flight hold and wrapped tags
        rst_cycle();
        for (int i = 0; i < 16; i++) begin
            idle(); rob_alloc_req = 2'b11; alloc_rd[0] = 5'd1; alloc_rd[1] = 5'd2;
            alloc_has_rd = 2'b11; #1; cycle();
        end
        chk("full_count", 64'(rob_count), 64'd32);
        idle(); rob_alloc_req = 2'b11; #1;
        chk("full_gnt", 64'(rob_alloc_gnt), 64'd0);
        cycle();
        idle(); cdb_valid = 2'b11; cdb_tag[0] = 5'd0; cdb_tag[1] = 5'd1;
        cdb_data[0] = 32'h100; cdb_data[1] = 32'h101; #1; cycle();
        idle(); #1; cycle();
        idle(); rob_alloc_req = 2'b11; alloc_rd[0] = 5'd4; alloc_rd[1] = 5'd6; alloc_has_rd = 2'b11;
        #1;
        chk("inflight_gnt", 64'(rob_alloc_gnt), 64'd0);
        cycle();
        #1;
        chk("wrap_gnt",  64'(rob_alloc_gnt), 64'd3);
        chk("wrap_tag0", 64'(rob_alloc_tags[0]), 64'd0);
        chk("wrap_tag1", 64'(rob_alloc_tags[1]), 64'd1);
        cycle();

        // Flush with 10 entries, 4 done; entry 0 has rd=0
        rst_cycle();
        for (int i = 0; i < 5; i++) begin
            idle(); rob_alloc_req = 2'b11; alloc_rd[0] = 5'(2 * i); alloc_rd[1] = 5'(2 * i + 1);
            alloc_has_rd = 2'b11; #1; cycle();
        end
        idle(); cdb_valid = 2'b11; cdb_tag[0] = 5'd0; cdb_tag[1] = 5'd1;
        cdb_data[0] = 32'h5; cdb_data[1] = 32'h6; #1; cycle();
        idle(); cdb_valid = 2'b11; cdb_tag[0] = 5'd2; cdb_tag[1] = 5'd3;
        cdb_data[0] = 32'h7; cdb_data[1] = 32'h8; #1; cycle();
        chk("fl_rd0_we", 64'(commit_write_ports[0].we), 64'd0);
        chk("fl_pre_we1", 64'(commit_write_ports[1].we), 64'd1);
        idle(); flush = 1'b1; rob_alloc_req = 2'b11; #1;
        chk("fl_gnt", 64'(rob_alloc_gnt), 64'd0);
        cycle();
        idle(); #1;
        chk("fl_empty", 64'(rob_empty), 64'd1);
        chk("fl_tag0",  64'(rob_alloc_tags[0]), 64'd0);
        chk("fl_we",    64'({commit_write_ports[1].we, commit_write_ports[0].we}), 64'd0);
        cycle();

        // Randomized traffic, alternating light and heavy writeback phases
        for (int n = 0; n < 4000; n++) begin
            idle();
            rate = ((n / 400) % 2 == 1) ? 15 : 60;
            rob_alloc_req = 2'($urandom_range(0, 3));
            alloc_has_rd  = 2'($urandom_range(0, 3));
            for (int s = 0; s < 2; s++)
                alloc_rd[s] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            for (int p = 0; p < 2; p++) begin
                cdb_valid[p] = ($urandom_range(0, 99) < rate);
                if (q.size() > 0 && $urandom_range(0, 9) != 0)
                    cdb_tag[p] = TAG_WIDTH'(q[$urandom_range(0, q.size() - 1)].tag);
                else
                    cdb_tag[p] = TAG_WIDTH'($urandom_range(0, ROB_DEPTH - 1));
                cdb_data[p] = $urandom;
            end
            flush = ($urandom_range(0, 299) == 0);
            #1;
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
